turn_scheduler: RTL and testbench

Game-flow controller for the Score-4 board. It decides which player owns the board each turn, and gates the local and remote movement and put pulses onto one shared board-write port. It runs a per-turn countdown and sequences win/full detection, game-over hold and board clear. It sits between the input synchronisers / opponent link and the panel register file.

---
 rtl/turn_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_turn_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - Score-4 turn, timer and board-write arbitration controller
module turn_scheduler #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int TURN_SECS = 30,
    parameter int HOLD_SECS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       self_left,
    input  logic       self_right,
    input  logic       self_put,
    input  logic       opp_left,
    input  logic       opp_right,
    input  logic       opp_put,
    input  logic       first_player,
    input  logic       drop_ack,
    input  logic       drop_invalid,
    input  logic       win_a,
    input  logic       win_b,
    input  logic       full_panel,
    output logic [6:0] col_sel,
    output logic       player,
    output logic       drop_req,
    output logic [2:0] drop_col,
    output logic       drop_player,
    output logic       invalid_move,
    output logic       timeout,
    output logic       board_clr,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [5:0] secs_left
);

    localparam int            PW          = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_DIV - 1);
    localparam logic [5:0]    TURN_RELOAD = 6'(TURN_SECS);
    localparam logic [5:0]    HOLD_RELOAD = 6'(HOLD_SECS);

    typedef enum logic [2:0] {IDLE, WAIT, DROP, CHECK, OVER} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic          chk_cnt, chk_cnt_n;
    logic [6:0]    col_sel_n;
    logic          player_n, drop_req_n, drop_player_n;
    logic [2:0]    drop_col_n, col_idx;
    logic          invalid_move_n, timeout_n, board_clr_n, game_over_n;
    logic [1:0]    winner_n;
    logic [5:0]    secs_left_n;
    logic          mv_left, mv_right, mv_put, tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            presc        <= '0;
            chk_cnt      <= 1'b0;
            col_sel      <= 7'b0000001;
            player       <= 1'b0;
            drop_req     <= 1'b0;
            drop_col     <= 3'd0;
            drop_player  <= 1'b0;
            invalid_move <= 1'b0;
            timeout      <= 1'b0;
            board_clr    <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'b00;
            secs_left    <= TURN_RELOAD;
        end else begin
            state        <= state_n;
            presc        <= presc_n;
            chk_cnt      <= chk_cnt_n;
            col_sel      <= col_sel_n;
            player       <= player_n;
            drop_req     <= drop_req_n;
            drop_col     <= drop_col_n;
            drop_player  <= drop_player_n;
            invalid_move <= invalid_move_n;
            timeout      <= timeout_n;
            board_clr    <= board_clr_n;
            game_over    <= game_over_n;
            winner       <= winner_n;
            secs_left    <= secs_left_n;
        end
    end

    always_comb begin
        col_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (col_sel[i]) col_idx = 3'(i);
        end
    end

    // Only the player who owns the turn may steer or drop.
    assign mv_left  = player ? opp_left  : self_left;
    assign mv_right = player ? opp_right : self_right;
    assign mv_put   = player ? opp_put   : self_put;
    assign tick     = (presc == PRESC_MAX);

    always_comb begin
        state_n        = state;
        presc_n        = presc;
        chk_cnt_n      = chk_cnt;
        col_sel_n      = col_sel;
        player_n       = player;
        drop_req_n     = drop_req;
        drop_col_n     = drop_col;
        drop_player_n  = drop_player;
        invalid_move_n = 1'b0;
        timeout_n      = 1'b0;
        board_clr_n    = 1'b0;
        game_over_n    = game_over;
        winner_n       = winner;
        secs_left_n    = secs_left;
        case (state)
            IDLE: begin
                board_clr_n = 1'b1;
                player_n    = first_player;
                col_sel_n   = 7'b0000001;
                state_n     = WAIT;
            end
            WAIT: begin
                if (mv_put) begin
                    drop_col_n    = col_idx;
                    drop_player_n = player;
                    drop_req_n    = 1'b1;
                    state_n       = DROP;
                end else begin
                    if (mv_left && !mv_right)
                        col_sel_n = {col_sel[0], col_sel[6:1]};
                    else if (mv_right && !mv_left)
                        col_sel_n = {col_sel[5:0], col_sel[6]};
                    if (tick) begin
                        presc_n = '0;
                        if (secs_left == 6'd1) begin
                            timeout_n   = 1'b1;
                            player_n    = ~player;
                            secs_left_n = TURN_RELOAD;
                        end else begin
                            secs_left_n = secs_left - 6'd1;
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
            end
            DROP: begin
                // A rejection wins even if the board also acked in that cycle.
                if (drop_invalid) begin
                    invalid_move_n = 1'b1;
                    drop_req_n     = 1'b0;
                    state_n        = WAIT;
                end else if (drop_ack) begin
                    drop_req_n = 1'b0;
                    chk_cnt_n  = 1'b0;
                    state_n    = CHECK;
                end
            end
            CHECK: begin
                if (!chk_cnt) begin
                    chk_cnt_n = 1'b1;
                end else if (win_a || win_b || full_panel) begin
                    winner_n    = {win_b, win_a};
                    game_over_n = 1'b1;
                    secs_left_n = HOLD_RELOAD;
                    presc_n     = '0;
                    state_n     = OVER;
                end else begin
                    player_n    = ~player;
                    secs_left_n = TURN_RELOAD;
                    presc_n     = '0;
                    state_n     = WAIT;
                end
            end
            OVER: begin
                if ((tick && secs_left == 6'd1) || self_put || opp_put) begin
                    board_clr_n = 1'b1;
                    game_over_n = 1'b0;
                    winner_n    = 2'b00;
                    player_n    = ~drop_player;
                    col_sel_n   = 7'b0000001;
                    secs_left_n = TURN_RELOAD;
                    presc_n     = '0;
                    state_n     = WAIT;
                end else if (tick) begin
                    presc_n     = '0;
                    secs_left_n = secs_left - 6'd1;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - directed self-checking bench for turn_scheduler
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       self_left = 1'b0, self_right = 1'b0, self_put = 1'b0;
    logic       opp_left = 1'b0, opp_right = 1'b0, opp_put = 1'b0;
    logic       first_player = 1'b0;
    logic       drop_ack = 1'b0, drop_invalid = 1'b0;
    logic       win_a = 1'b0, win_b = 1'b0, full_panel = 1'b0;
    logic [6:0] col_sel;
    logic       player, drop_req, drop_player, invalid_move, timeout, board_clr, game_over;
    logic [2:0] drop_col;
    logic [1:0] winner;
    logic [5:0] secs_left;

    int checks = 0;
    int failures = 0;

    turn_scheduler #(.CLK_DIV(4), .TURN_SECS(3), .HOLD_SECS(2)) dut (
        .clk(clk), .rst(rst),
        .self_left(self_left), .self_right(self_right), .self_put(self_put),
        .opp_left(opp_left), .opp_right(opp_right), .opp_put(opp_put),
        .first_player(first_player), .drop_ack(drop_ack), .drop_invalid(drop_invalid),
        .win_a(win_a), .win_b(win_b), .full_panel(full_panel),
        .col_sel(col_sel), .player(player), .drop_req(drop_req), .drop_col(drop_col),
        .drop_player(drop_player), .invalid_move(invalid_move), .timeout(timeout),
        .board_clr(board_clr), .game_over(game_over), .winner(winner), .secs_left(secs_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the DUT in WAIT with prescaler 0 and secs_left 3.
    task automatic do_reset(input logic fp);
        first_player = fp;
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    initial begin
        // reset values while held
        first_player = 1'b1;
        cyc(2);
        chk("rst_col", 32'(col_sel), 32'h01);
        chk("rst_player", 32'(player), 0);
        chk("rst_secs", 32'(secs_left), 3);
        chk("rst_clr", 32'(board_clr), 0);
        chk("rst_dreq", 32'(drop_req), 0);
        chk("rst_over", 32'(game_over), 0);

        // release with B starting
        rst = 1'b1;
        cyc(1);
        chk("idle_clr", 32'(board_clr), 1);
        chk("idle_player", 32'(player), 1);
        chk("idle_col", 32'(col_sel), 32'h01);
        chk("idle_secs", 32'(secs_left), 3);
        cyc(1);
        chk("idle_clr_drop", 32'(board_clr), 0);

        // movement for player A
        do_reset(1'b0);
        chk("a_player", 32'(player), 0);
        self_left = 1'b1; cyc(1); self_left = 1'b0;
        chk("left_wrap", 32'(col_sel), 32'h40);
        self_right = 1'b1; cyc(1); self_right = 1'b0;
        chk("right_wrap", 32'(col_sel), 32'h01);
        opp_right = 1'b1; cyc(1); opp_right = 1'b0;
        chk("opp_ignored", 32'(col_sel), 32'h01);
        self_left = 1'b1; self_right = 1'b1; cyc(1); self_left = 1'b0; self_right = 1'b0;
        chk("lr_cancel", 32'(col_sel), 32'h01);
        chk("first_tick", 32'(secs_left), 2);

        // put in column 3 and a slow ack
        do_reset(1'b0);
        repeat (3) begin self_right = 1'b1; cyc(1); self_right = 1'b0; end
        chk("col3", 32'(col_sel), 32'h08);
        self_put = 1'b1; cyc(1); self_put = 1'b0;
        chk("put_req", 32'(drop_req), 1);
        chk("put_col", 32'(drop_col), 3);
        chk("put_plr", 32'(drop_player), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("req_hold", 32'(drop_req), 1);
        end
        drop_ack = 1'b1; cyc(1); drop_ack = 1'b0;
        chk("ack_req_low", 32'(drop_req), 0);
        chk("ack_plr_m1", 32'(player), 0);
        cyc(1);
        chk("ack_plr_m2", 32'(player), 0);
        cyc(1);
        chk("ack_plr_m3", 32'(player), 1);
        chk("ack_secs", 32'(secs_left), 3);

        // invalid drop by B keeps the running timer
        cyc(5);
        chk("b_secs", 32'(secs_left), 2);
        opp_put = 1'b1; cyc(1); opp_put = 1'b0;
        chk("b_req", 32'(drop_req), 1);
        chk("b_dplr", 32'(drop_player), 1);
        drop_invalid = 1'b1; cyc(1); drop_invalid = 1'b0;
        chk("inv_pulse", 32'(invalid_move), 1);
        chk("inv_req", 32'(drop_req), 0);
        chk("inv_player", 32'(player), 1);
        chk("inv_secs", 32'(secs_left), 2);
        cyc(1);
        chk("inv_one", 32'(invalid_move), 0);
        opp_put = 1'b1; cyc(1); opp_put = 1'b0;
        drop_ack = 1'b1; drop_invalid = 1'b1; cyc(1); drop_ack = 1'b0; drop_invalid = 1'b0;
        chk("both_inv", 32'(invalid_move), 1);
        cyc(3);
        chk("both_player", 32'(player), 1);

        // turn timeout
        do_reset(1'b0);
        cyc(4);
        chk("to_secs2", 32'(secs_left), 2);
        cyc(4);
        chk("to_secs1", 32'(secs_left), 1);
        cyc(3);
        chk("to_early", 32'(timeout), 0);
        cyc(1);
        chk("to_pulse", 32'(timeout), 1);
        chk("to_player", 32'(player), 1);
        chk("to_reload", 32'(secs_left), 3);
        chk("to_col", 32'(col_sel), 32'h01);
        cyc(1);
        chk("to_one", 32'(timeout), 0);

        // put on the expiring tick wins, then A wins the game
        do_reset(1'b0);
        cyc(11);
        self_put = 1'b1; cyc(1); self_put = 1'b0;
        chk("pt_timeout", 32'(timeout), 0);
        chk("pt_req", 32'(drop_req), 1);
        chk("pt_player", 32'(player), 0);
        win_a = 1'b1;
        drop_ack = 1'b1; cyc(1); drop_ack = 1'b0;
        cyc(2);
        chk("win_over", 32'(game_over), 1);
        chk("win_who", 32'(winner), 32'b01);
        chk("win_hold", 32'(secs_left), 2);
        win_a = 1'b0;
        cyc(7);
        chk("hold_still", 32'(game_over), 1);
        cyc(1);
        chk("exp_clr", 32'(board_clr), 1);
        chk("exp_over", 32'(game_over), 0);
        chk("exp_winner", 32'(winner), 0);
        chk("exp_player", 32'(player), 1);
        chk("exp_secs", 32'(secs_left), 3);

        // B wins, opp_put leaves OVER early
        win_b = 1'b1;
        opp_put = 1'b1; cyc(1); opp_put = 1'b0;
        drop_ack = 1'b1; cyc(1); drop_ack = 1'b0;
        cyc(2);
        chk("bwin_who", 32'(winner), 32'b10);
        win_b = 1'b0;
        self_left = 1'b1; cyc(1); self_left = 1'b0;
        chk("over_nomove", 32'(col_sel), 32'h01);
        opp_put = 1'b1; cyc(1); opp_put = 1'b0;
        chk("put_exit_clr", 32'(board_clr), 1);
        chk("put_exit_over", 32'(game_over), 0);
        chk("put_exit_plr", 32'(player), 0);

        // asynchronous reset in the middle of a drop
        cyc(1);
        self_put = 1'b1; cyc(1); self_put = 1'b0;
        chk("pre_rst_req", 32'(drop_req), 1);
        rst = 1'b0;
        #1;
        chk("async_req", 32'(drop_req), 0);
        chk("async_secs", 32'(secs_left), 3);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("rerun_clr", 32'(board_clr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
